// File: rtl/mips_mem_loader.sv
// mips_mem_loader
//   Host-side loader for a small MIPS system. A 32-bit command stream drives
//   block writes into the processor memory, block readback and a run request.
//   A run releases the processor and reports how many cycles it took to halt.
//
//   Command word: op=[31:30] count=[29:20] addr=[ADDR_W-1:0]
//     op 01 : WRITE, the next <count> stream words are stored from addr upward
//     op 10 : READ,  <count> words from addr upward are returned on out stream
//     op 11 : RUN,   pulse cpu_start, wait for cpu_halted,
//                    then return {16'hD0E0, cycles}
//     op 00, or count 0 with op 01/10 : sets the sticky error flag, no action
//
// Ports
//   clk1, reset                  : clock, synchronous active-high reset
//   in_valid/in_ready/in_data    : host command/data stream (sink)
//   out_valid/out_ready/out_data : readback/status stream (source)
//   mem_we/mem_addr/mem_wdata    : memory write port and address
//   mem_rdata                    : memory read data, one cycle after mem_addr
//   cpu_start, cpu_halted        : processor release pulse, HALTED flag
//   busy, error                  : not-idle indicator, sticky protocol error
//
// Handshake: a word moves on a stream only in a cycle where valid and ready
// are both high at the rising clock edge. A source holds valid and data stable
// until that happens. valid never waits on ready. reset wins over any
// handshake in the same cycle, so a word offered in a reset cycle is dropped.
module mips_mem_loader #(
   parameter int ADDR_W = 10
) (
   input  logic              clk1,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_data,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   output logic              cpu_start,
   input  logic              cpu_halted,
   output logic              busy,
   output logic              error
);

   typedef enum logic [2:0] {
      IDLE, WRITE, RD_ADDR, RD_WAIT, RD_OUT, RUN_PULSE, RUN_WAIT, RUN_OUT
   } state_t;

   localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] addr, addr_nxt;
   logic [9:0]        count, count_nxt;
   logic [15:0]       cyc, cyc_nxt;
   logic [31:0]       rd_data, rd_data_nxt;
   logic              error_nxt;
   logic              accept;
   logic [1:0]        cmd_op;
   logic [9:0]        cmd_count;

   assign cmd_op    = in_data[31:30];
   assign cmd_count = in_data[29:20];

   always_ff @(posedge clk1) begin
      if (reset) begin
         state   <= IDLE;
         addr    <= '0;
         count   <= '0;
         cyc     <= '0;
         rd_data <= '0;
         error   <= 1'b0;
      end else begin
         state   <= state_nxt;
         addr    <= addr_nxt;
         count   <= count_nxt;
         cyc     <= cyc_nxt;
         rd_data <= rd_data_nxt;
         error   <= error_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      addr_nxt    = addr;
      count_nxt   = count;
      cyc_nxt     = cyc;
      rd_data_nxt = rd_data;
      error_nxt   = error;
      mem_we      = 1'b0;
      mem_wdata   = '0;
      cpu_start   = 1'b0;
      out_valid   = 1'b0;
      // Outputs that complete a transfer are masked during reset so that a
      // reset cycle can neither write memory nor hand out a word.
      in_ready    = !reset && (state == IDLE || state == WRITE);
      accept      = in_valid && in_ready;

      case (state)
         IDLE: begin
            if (accept) begin
               unique case (cmd_op)
                  2'b01, 2'b10: begin
                     if (cmd_count != 10'd0) begin
                        addr_nxt  = in_data[ADDR_W-1:0];
                        count_nxt = cmd_count;
                        state_nxt = (cmd_op == 2'b01) ? WRITE : RD_ADDR;
                     end else begin
                        error_nxt = 1'b1;
                     end
                  end
                  2'b11:   state_nxt = RUN_PULSE;
                  default: error_nxt = 1'b1;
               endcase
            end
         end
         WRITE: begin
            if (accept) begin
               mem_we    = 1'b1;
               mem_wdata = in_data;
               addr_nxt  = addr + ADDR_ONE;
               count_nxt = count - 10'd1;
               if (count == 10'd1) state_nxt = IDLE;
            end
         end
         // mem_addr is presented here; the synchronous memory answers in
         // RD_WAIT, where the word is captured.
         RD_ADDR: state_nxt = RD_WAIT;
         RD_WAIT: begin
            rd_data_nxt = mem_rdata;
            state_nxt   = RD_OUT;
         end
         RD_OUT: begin
            out_valid = !reset;
            if (out_ready) begin
               addr_nxt  = addr + ADDR_ONE;
               count_nxt = count - 10'd1;
               state_nxt = (count == 10'd1) ? IDLE : RD_ADDR;
            end
         end
         RUN_PULSE: begin
            cpu_start = !reset;
            cyc_nxt   = '0;
            state_nxt = RUN_WAIT;
         end
         // Every RUN_WAIT cycle counts, including the one that sees the halt,
         // so a processor already halted on entry reports 1.
         RUN_WAIT: begin
            if (cyc != 16'hFFFF) cyc_nxt = cyc + 16'd1;
            if (cpu_halted) state_nxt = RUN_OUT;
         end
         RUN_OUT: begin
            out_valid = !reset;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign out_data = (state == RUN_OUT) ? {16'hD0E0, cyc} : rd_data;
   assign mem_addr = addr;
   assign busy     = (state != IDLE);

endmodule

// File: tb/tb_mips_mem_loader.sv
// tb_mips_mem_loader
//   Self-checking bench for mips_mem_loader. A behavioural memory and processor
//   sit around the DUT. The expected stream and write traffic come from a
//   reference copy of memory updated by command-level tasks. Run cycle count:
//   if cpu_halted is first seen high d cycles after the cpu_start cycle, the
//   report is d (1 when already halted on entry).
module tb_mips_mem_loader;

   localparam int ADDR_W = 10;
   localparam int MEM_N  = 1 << ADDR_W;

   logic              clk1 = 1'b0;
   logic              reset = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [31:0]       in_data = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [31:0]       out_data;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata = '0;
   logic              cpu_start;
   logic              cpu_halted = 1'b0;
   logic              busy;
   logic              error;

   mips_mem_loader #(.ADDR_W(ADDR_W)) dut (
      .clk1(clk1), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .cpu_start(cpu_start), .cpu_halted(cpu_halted),
      .busy(busy), .error(error)
   );

   // ---------------- clock / environment ----------------
   always #5 clk1 = ~clk1;

   logic [31:0] mem     [MEM_N];
   logic [31:0] ref_mem [MEM_N];

   always @(posedge clk1) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
   end

   // ---------------- scoreboard state ----------------
   int n_tests = 0;
   int n_fail  = 0;
   int cycle   = 0;
   int n_wr    = 0;
   int n_start = 0;
   int halt_delay = 0;
   bit rand_rdy = 1'b0;
   logic [31:0]        exp_q[$];
   logic [ADDR_W+31:0] exp_wr_q[$];
   logic [31:0]        wr_data_q[$];
   int                 hs_t[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cycle);
      end
   endtask

   // Monitor: samples on the falling edge, inputs change at posedge+1.
   logic        have_hold = 1'b0;
   logic [31:0] hold_data = '0;
   initial begin
      forever begin
         @(negedge clk1);
         cycle++;
         if (reset) begin
            have_hold = 1'b0;
         end else begin
            if (have_hold) check("out_stable", {out_valid, out_data}, {1'b1, hold_data});
            if (mem_we) begin
               n_wr++;
               if (exp_wr_q.size() == 0) check("wr_unexpected", mem_we, 0);
               else check("wr", {mem_addr, mem_wdata}, exp_wr_q.pop_front());
            end
            if (out_valid && out_ready) begin
               hs_t.push_back(cycle);
               if (exp_q.size() == 0) check("out_unexpected", out_valid, 0);
               else check("out", out_data, exp_q.pop_front());
            end
            have_hold = out_valid && !out_ready;
            hold_data = out_data;
         end
      end
   end

   // Processor model: raises HALTED halt_delay cycles after the start cycle.
   initial begin
      forever begin
         @(negedge clk1);
         if (cpu_start === 1'b1 && !reset) begin
            n_start++;
            @(negedge clk1);
            check("start_pulse", cpu_start, 0);
            if (halt_delay > 0) begin
               if (halt_delay > 1) begin
                  repeat (halt_delay - 1) @(posedge clk1);
                  #1;
               end
               cpu_halted = 1'b1;
            end
         end
      end
   end

   // Random backpressure on the out stream.
   initial begin
      forever begin
         @(posedge clk1);
         #1;
         if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      end
   end

   // ---------------- driver tasks ----------------
   function automatic logic [31:0] mk_cmd(input logic [1:0] op, input int n, input int a);
      logic [9:0] c;
      logic [9:0] ad;
      c  = n[9:0];
      ad = a[9:0];
      return {op, c, 10'd0, ad};
   endfunction

   task automatic send(input logic [31:0] d);
      int n;
      n = 0;
      @(posedge clk1);
      #1;
      in_valid = 1'b1;
      in_data  = d;
      while (!in_ready && n < 2000) begin
         @(posedge clk1);
         #1;
         n++;
      end
      if (!in_ready) check("send_timeout", in_ready, 1);
      @(posedge clk1);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic do_write(input int a, input int n);
      logic [31:0] d;
      logic [ADDR_W-1:0] aa;
      send(mk_cmd(2'b01, n, a));
      for (int i = 0; i < n; i++) begin
         aa = ADDR_W'((a + i) % MEM_N);
         d  = (wr_data_q.size() != 0) ? wr_data_q.pop_front() : $urandom;
         ref_mem[aa] = d;
         exp_wr_q.push_back({aa, d});
         send(d);
      end
   endtask

   task automatic do_read(input int a, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(ref_mem[(a + i) % MEM_N]);
      send(mk_cmd(2'b10, n, a));
   endtask

   task automatic do_run(input int d);
      exp_q.push_back({16'hD0E0, 16'((d == 0) ? 1 : d)});
      halt_delay = d;
      cpu_halted = (d == 0);
      send(32'hC000_0000);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy || exp_q.size() != 0 || exp_wr_q.size() != 0) && n < 5000) begin
         @(negedge clk1);
         n++;
      end
      check("drain_timeout", n < 5000, 1);
   endtask

   task automatic apply_reset();
      @(posedge clk1);
      #1;
      reset = 1'b1;
      @(posedge clk1);
      #1;
      reset = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_in_ready"}, in_ready, 1);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_out_data"}, out_data, 0);
      check({tag, "_mem_we"}, mem_we, 0);
      check({tag, "_mem_addr"}, mem_addr, 0);
      check({tag, "_mem_wdata"}, mem_wdata, 0);
      check({tag, "_cpu_start"}, cpu_start, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_error"}, error, 0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int wr0, st0, a, n, op;
      for (int i = 0; i < MEM_N; i++) begin
         logic [31:0] v;
         v = $urandom;
         mem[i]     <= v;
         ref_mem[i] = v;
      end
      repeat (3) @(posedge clk1);
      #1;
      reset = 1'b0;
      @(negedge clk1);
      check_reset_vals("reset");

      // Program load at address 0.
      rand_rdy = 1'b0;
      out_ready = 1'b1;
      wr0 = n_wr;
      wr_data_q = '{32'h28010078, 32'h0c631800, 32'h20220000, 32'h0c631800,
                    32'h2842002d, 32'h0c631800, 32'h24220001, 32'hfc000000};
      do_write(0, 8);
      @(negedge clk1);
      check("prog_busy_fall", busy, 0);
      check("prog_writes", n_wr - wr0, 8);
      check("prog_mem7", mem[7], 32'hfc000000);

      // Write 85 at 120, read back 120..121.
      wr_data_q = '{32'd85};
      do_write(120, 1);
      hs_t.delete();
      do_read(120, 2);
      wait_idle();
      check("rd_hs_count", hs_t.size(), 2);
      if (hs_t.size() == 2) check("rd_gap_ge2", (hs_t[1] - hs_t[0]) >= 2, 1);

      // Read across the top of memory with a stalled sink.
      out_ready = 1'b0;
      do_read(1023, 2);
      n = 0;
      while (!out_valid && n < 100) begin
         @(negedge clk1);
         n++;
      end
      check("stall_valid", out_valid, 1);
      repeat (5) @(negedge clk1);
      @(posedge clk1);
      #1;
      out_ready = 1'b1;
      wait_idle();

      // Run, processor halts 40 cycles after start.
      st0 = n_start;
      do_run(40);
      wait_idle();
      check("run_starts", n_start - st0, 1);
      st0 = n_start;
      do_run(0);
      wait_idle();
      check("run_halted_entry_starts", n_start - st0, 1);

      // Protocol errors: each sets error, neither writes.
      wr0 = n_wr;
      apply_reset();
      send(32'h0000_0000);
      @(negedge clk1);
      check("err_op00", error, 1);
      check("err_op00_busy", busy, 0);
      apply_reset();
      send(32'h4000_0005);
      @(negedge clk1);
      check("err_cnt0", error, 1);
      check("err_no_writes", n_wr - wr0, 0);
      do_write(16, 3);
      wait_idle();
      check("err_sticky", error, 1);
      check("err_then_write", n_wr - wr0, 3);

      // Reset during the third word of an eight-word write.
      apply_reset();
      wr0 = n_wr;
      send(mk_cmd(2'b01, 8, 200));
      for (int i = 0; i < 2; i++) begin
         logic [31:0] d;
         logic [ADDR_W-1:0] aa;
         d  = $urandom;
         aa = ADDR_W'(200 + i);
         ref_mem[aa] = d;
         exp_wr_q.push_back({aa, d});
         send(d);
      end
      @(posedge clk1);
      #1;
      in_valid = 1'b1;
      in_data  = 32'hDEAD_BEEF;
      reset    = 1'b1;
      @(posedge clk1);
      #1;
      reset    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk1);
      check_reset_vals("midwr");
      check("midwr_writes", n_wr - wr0, 2);
      check("midwr_mem202", mem[202], ref_mem[202]);

      // Randomized command mix with random backpressure.
      rand_rdy = 1'b1;
      for (int k = 0; k < 40; k++) begin
         op = $urandom_range(0, 2);
         n  = $urandom_range(1, 6);
         a  = ($urandom_range(0, 3) == 0) ? 1020 + $urandom_range(0, 3) : $urandom_range(0, MEM_N - 1);
         case (op)
            0:       do_write(a, n);
            1:       do_read(a, n);
            default: do_run($urandom_range(0, 30));
         endcase
         wait_idle();
      end
      rand_rdy = 1'b0;
      check("final_exp_empty", exp_q.size(), 0);
      check("final_wr_empty", exp_wr_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mips_mem_loader.md
MIPS_MEM_LOADER -- requirements
Module: mips_mem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning memory word-address width (1024 words).
REQ-002 SHALL have port clk1, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, 32): host command/data stream.
REQ-005 SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_data (output, 32): readback/status stream.
REQ-006 SHALL have ports mem_we (output, 1), mem_addr (output, ADDR_W), mem_wdata (output, 32) and mem_rdata (input, 32): memory port with 1-cycle synchronous read.
REQ-007 SHALL have ports cpu_start (output, 1), a processor release pulse, and cpu_halted (input, 1), the processor HALTED flag.
REQ-008 SHALL have ports busy (output, 1), high whenever state is not IDLE, and error (output, 1), a sticky protocol error flag.

Function
REQ-009 SHALL accept an in_data word only on a cycle with in_valid and in_ready both high.
REQ-010 SHALL decode each command word as op=[31:30], count=[29:20], addr=[ADDR_W-1:0].
REQ-011 SHALL use states IDLE, WRITE, RD_ADDR, RD_WAIT, RD_OUT, RUN_PULSE, RUN_WAIT and RUN_OUT.
REQ-012 SHALL hold in_ready=1 only in IDLE and WRITE.
REQ-013 IDLE: op=01 with count!=0 -> WRITE; op=10 with count!=0 -> RD_ADDR; op=11 -> RUN_PULSE; op=00 or count=0 -> set error, stay IDLE.
REQ-014 WRITE: each accepted word SHALL drive mem_we=1, mem_addr=current address and mem_wdata=in_data in the same cycle; the address then increments and the remaining count decrements; the last word returns the block to IDLE.
REQ-015 mem_we SHALL be 0 in every cycle without an accepted WRITE word.
REQ-016 RD_ADDR SHALL drive mem_addr for one cycle, then go to RD_WAIT.
REQ-017 RD_WAIT SHALL capture mem_rdata into out_data, set out_valid=1, then go to RD_OUT.
REQ-018 RD_OUT SHALL hold out_data and out_valid stable until out_ready=1, then:
- clear out_valid;
- increment the address and decrement the count;
- go to RD_ADDR, or to IDLE when the count is exhausted.
REQ-019 Address increment SHALL wrap modulo 2^ADDR_W (1023 -> 0) with no error.
REQ-020 RUN_PULSE SHALL drive cpu_start=1 for exactly one cycle, clear the 16-bit cycle counter, then go to RUN_WAIT.
REQ-021 RUN_WAIT SHALL increment the cycle counter each cycle, saturating at 16'hFFFF.
REQ-022 RUN_WAIT SHALL move to RUN_OUT on the first cycle cpu_halted=1, including when cpu_halted is already 1 on entry.
REQ-023 RUN_OUT SHALL present out_data={16'hD0E0, cycle counter} with out_valid=1 until out_ready=1, then go to IDLE.
REQ-024 in_valid asserted while in_ready=0 SHALL be ignored and SHALL NOT set error.
REQ-025 error SHALL stay set until reset; the block SHALL keep operating normally while it is set.

Reset
REQ-026 reset SHALL set, on the next clk1 edge: state IDLE; in_ready=1; out_valid=0; out_data=0; mem_we=0; mem_addr=0; mem_wdata=0; cpu_start=0; busy=0; error=0; count=0; cycle counter=0.
REQ-027 reset asserted mid-operation (any state) SHALL abort the operation with no further memory write and drop any pending out word.
REQ-028 reset SHALL take priority over every simultaneous handshake.

Verification
REQ-029 WRITE cmd 0x40800000 (count 8, addr 0), then 0x28010078, 0x0c631800, 0x20220000, 0x0c631800, 0x2842002d, 0x0c631800, 0x24220001, 0xfc000000 -> 8 mem_we pulses at addresses 0..7 with matching data; busy falls after the last word.
REQ-030 WRITE cmd 0x40100078 + data 85; READ cmd 0x80200078 with out_ready=1 -> out words 85 then mem[121]; 2+ cycles per word.
REQ-031 READ count 2 at addr 1023, with out_ready held low 5 cycles -> out_data stable through the stall; addresses read are 1023 then 0.
REQ-032 RUN cmd 0xC0000000, model raises cpu_halted 40 cycles after cpu_start -> one cpu_start pulse; out_data=0xD0E00028 (±1 per the counting convention documented in the bench).
REQ-033 Cmd 0x00000000 then cmd 0x40000005 -> error=1 after each, no mem_we; a following valid WRITE succeeds.
REQ-034 reset in the 3rd word of an 8-word WRITE -> exactly 2 writes, all outputs at reset values next cycle.
